// File: rtl/fetch_sequencer.sv
// fetch_sequencer: control FSM sequencing PC, program ROM and fetch register of the 4-bit CPU
module fetch_sequencer #(
    parameter int         ADDR_W  = 12,
    parameter logic [3:0] OP_JZ   = 4'hC,
    parameter logic [3:0] OP_JC   = 4'hD,
    parameter logic [3:0] OP_JMP  = 4'hE,
    parameter logic [3:0] OP_HALT = 4'hF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              run,
    input  logic              step,
    input  logic [3:0]        instr,
    input  logic [3:0]        oprnd,
    input  logic [7:0]        rom_data,
    input  logic              flag_z,
    input  logic              flag_c,
    output logic              pc_en,
    output logic              pc_load,
    output logic [ADDR_W-1:0] pc_load_val,
    output logic              fetch_en,
    output logic              exec_en,
    output logic              halted,
    output logic [2:0]        state_o
);
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        DECODE = 3'd2,
        EXEC   = 3'd3,
        JUMP   = 3'd4,
        HALT   = 3'd5
    } state_t;

    state_t     state, state_nx;
    logic [7:0] addr_lo;
    logic [3:0] addr_hi;
    logic [3:0] op_q;
    logic       sstep;
    logic       is_jmp;
    logic       taken;

    assign is_jmp = instr == OP_JMP || instr == OP_JZ || instr == OP_JC;
    assign taken  = op_q == OP_JMP || (op_q == OP_JZ && flag_z) || (op_q == OP_JC && flag_c);

    assign fetch_en    = state == FETCH;
    assign pc_en       = state == FETCH || (state == DECODE && is_jmp);
    assign exec_en     = state == EXEC;
    assign pc_load     = state == JUMP && taken;
    assign halted      = state == HALT;
    assign state_o     = state;
    assign pc_load_val = ADDR_W'({addr_hi, addr_lo});

    // state register plus jump target / opcode capture and single-step latch
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            addr_lo <= '0;
            addr_hi <= '0;
            op_q    <= '0;
            sstep   <= 1'b0;
        end else begin
            state <= state_nx;
            if (state == IDLE && (run || step))
                sstep <= !run;
            if (state == DECODE && is_jmp) begin
                addr_lo <= rom_data;
                addr_hi <= oprnd;
                op_q    <= instr;
            end
        end
    end

    // next-state decode; run beats step, HALT only leaves through reset
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:       state_nx = (run || step) ? FETCH : IDLE;
            FETCH:      state_nx = DECODE;
            DECODE:     state_nx = instr == OP_HALT ? HALT : is_jmp ? JUMP : EXEC;
            EXEC, JUMP: state_nx = (run && !sstep) ? FETCH : IDLE;
            HALT:       state_nx = HALT;
            default:    state_nx = IDLE;
        endcase
    end
endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Control FSM that sequences the 12-bit program counter, the program ROM and the 8-bit fetch register of the 4-bit CPU datapath.
- Drives PC enable, PC load and fetch enable; decodes the fetched opcode; handles two-byte jump instructions; issues an execute strobe to the ALU/accumulator stage.
- Supports free-run, single-step and halt.

Parameters:
- ADDR_W, 12, PC / ROM address width.
- OP_JZ, 4'hC, opcode: jump if flag_z.
- OP_JC, 4'hD, opcode: jump if flag_c.
- OP_JMP, 4'hE, opcode: unconditional jump.
- OP_HALT, 4'hF, opcode: stop sequencing.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- run  in  1  level; 1 = execute continuously.
- step  in  1  one-cycle pulse; execute exactly one instruction from IDLE.
- instr  in  4  opcode from the fetch register.
- oprnd  in  4  operand from the fetch register.
- rom_data  in  8  ROM output at the current PC.
- flag_z  in  1  zero flag from the datapath.
- flag_c  in  1  carry flag from the datapath.
- pc_en  out  1  PC increment enable.
- pc_load  out  1  PC parallel-load strobe.
- pc_load_val  out  ADDR_W  PC load value.
- fetch_en  out  1  fetch-register capture enable.
- exec_en  out  1  one-cycle execute strobe to the datapath.
- halted  out  1  1 while in HALT.
- state_o  out  3  current state encoding, for debug.

Behaviour:
- States and encoding: IDLE=0, FETCH=1, DECODE=2, EXEC=3, JUMP=4, HALT=5.
- Reset (reset=0, asynchronous):
  - State becomes IDLE.
  - pc_en, pc_load, fetch_en, exec_en and halted go to 0; pc_load_val becomes 0; internal addr_lo register becomes 0.
  - Reset mid-instruction aborts it: no further strobes are issued.
- Outputs are Moore-decoded from the state register; pc_load_val and addr_lo are registered.
- IDLE: no strobes. If run=1 or step=1 -> FETCH. If both are high, run takes precedence. The step request is remembered as single-step mode.
- FETCH (1 cycle): fetch_en=1 and pc_en=1. The fetch register captures ROM[PC] and PC becomes PC+1 on the same edge. -> DECODE.
- DECODE (1 cycle): instr and oprnd are valid.
  - instr=OP_HALT -> HALT.
  - instr in {OP_JMP, OP_JZ, OP_JC}: capture addr_lo <= rom_data (second byte, at PC) and assert pc_en=1 to skip that byte. -> JUMP.
  - Any other opcode -> EXEC.
- EXEC (1 cycle): exec_en=1.
  - run=1 and not single-step mode -> FETCH; otherwise -> IDLE.
- JUMP (1 cycle):
  - Taken when: OP_JMP always; OP_JZ if flag_z=1; OP_JC if flag_c=1. Flags are sampled in this cycle.
  - Taken: pc_load=1 with pc_load_val={oprnd, addr_lo}; the PC loads on the next edge.
  - Not taken: no strobe; PC already points past the second byte.
  - Next state follows the same run/step rule as EXEC.
- HALT: halted=1, no strobes; run and step are ignored. Only reset exits.
- Exclusivity: pc_en and pc_load are never asserted in the same cycle. exec_en is never asserted together with any PC strobe.
- Single-step: one instruction per step pulse. Cycles per instruction: 3 for a non-jump (FETCH/DECODE/EXEC), 3 for a jump (FETCH/DECODE/JUMP).
- run deasserted mid-instruction: the current instruction completes, then the FSM returns to IDLE.
- Wrap-around: PC is modulo 2^ADDR_W. A jump opcode at 0xFFF takes its second byte from 0x000.
- step pulses arriving outside IDLE are ignored (no queuing).

Test Plan:
- Reset low, then release with run=0: all outputs 0, state_o=0 and stays 0; pulse step with ROM[0]=8'h21 -> FETCH/DECODE/EXEC with exec_en high for 1 cycle, PC=1, back in IDLE.
- run=1, ROM[0..2]=8'h12,8'h34,8'h56 -> three exec_en pulses spaced 3 cycles apart; PC reads 3 after 9 cycles.
- ROM[0]=8'hE5, ROM[1]=8'hA7, run=1 -> pc_load=1 with pc_load_val=12'h5A7 in the JUMP cycle; the next FETCH reads address 0x5A7.
- ROM[0]=8'hC1, ROM[1]=8'h00: with flag_z=0 -> no pc_load and the next fetch is at 0x002; with flag_z=1 -> pc_load_val=12'h100.
- ROM[n]=8'hF0 -> halted=1 from the cycle after DECODE; run and step are ignored; reset low clears halted and state_o becomes 0 immediately, without a clock edge.
- Reset asserted during JUMP -> pc_load drops asynchronously and no load occurs; a jump at 0xFFF with ROM[0x000]=8'h12 and opcode 8'hE3 -> pc_load_val=12'h312.
